// File: rtl/output_bank_scheduler.sv
// Round-robin time-sharing of one static output bank among NREQ requesters.
// Optional OUTPUT_BANK_ABORT_EN adds an abort input that cuts DRIVE short.
module output_bank_scheduler #(
    parameter int WIDTH  = 40,
    parameter int NREQ   = 4,
    parameter int HOLD_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_pattern,
    input  logic [NREQ*HOLD_W-1:0]   req_hold,
`ifdef OUTPUT_BANK_ABORT_EN
    input  logic                     abort,
`endif
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [WIDTH-1:0]         out_bus,
    output logic                     busy,
    output logic [2:0]               owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;

    logic [1:0]        r_state;
    logic [2:0]        r_ptr;
    logic [2:0]        r_owner;
    logic [HOLD_W-1:0] r_cnt;
    logic [WIDTH-1:0]  r_out;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;

    logic              w_found;
    logic [2:0]        w_win;
    logic [WIDTH-1:0]  w_pat;
    logic [HOLD_W-1:0] w_hold;
    logic [NREQ-1:0]   w_win_oh;
    logic [NREQ-1:0]   w_own_oh;
    logic              w_abort;

`ifdef OUTPUT_BANK_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Two passes: indices above the pointer first, then wrap to the rest.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_pat   = '0;
        w_hold  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[k] && k > int'(r_ptr)) begin
                w_found = 1'b1;
                w_win   = 3'(k);
                w_pat   = req_pattern[k*WIDTH +: WIDTH];
                w_hold  = req_hold[k*HOLD_W +: HOLD_W];
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[k] && k <= int'(r_ptr)) begin
                w_found = 1'b1;
                w_win   = 3'(k);
                w_pat   = req_pattern[k*WIDTH +: WIDTH];
                w_hold  = req_hold[k*HOLD_W +: HOLD_W];
            end
        end
    end

    assign w_win_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_own_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'(NREQ-1);
            r_owner <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                S_IDLE, S_GUARD: begin
                    if (w_found) begin
                        r_state <= S_DRIVE;
                        r_gnt   <= w_win_oh;
                        r_out   <= w_pat;
                        r_cnt   <= (w_hold == '0) ? HOLD_W'(1) : w_hold;
                        r_owner <= w_win;
                        r_ptr   <= w_win;
                    end else begin
                        r_state <= S_IDLE;
                        r_out   <= '0;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == HOLD_W'(1) || w_abort) begin
                        r_state <= S_GUARD;
                        r_out   <= '0;
                        r_done  <= w_own_oh;
                    end else begin
                        r_cnt <= r_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_out   <= '0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign out_bus = r_out;
    assign busy    = (r_state != S_IDLE);
    assign owner   = r_owner;

endmodule

// File: tb/tb_output_bank_scheduler.sv
// Directed table-driven bench for output_bank_scheduler.
// Abort sequence is exercised only when OUTPUT_BANK_ABORT_EN is defined.
module tb_output_bank_scheduler;

    localparam int WIDTH  = 40;
    localparam int NREQ   = 4;
    localparam int HOLD_W = 8;

    localparam logic [39:0] P0 = 40'h11_1111_1111;
    localparam logic [39:0] P1 = 40'h22_2222_2222;
    localparam logic [39:0] P2 = 40'hA5_0000_00FF;
    localparam logic [39:0] P3 = 40'h33_3333_3333;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*WIDTH-1:0]  req_pattern;
    logic [NREQ*HOLD_W-1:0] req_hold;
`ifdef OUTPUT_BANK_ABORT_EN
    logic                   abort;
`endif
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [WIDTH-1:0]       out_bus;
    logic                   busy;
    logic [2:0]             owner;

    int n_tests = 0;
    int n_fail  = 0;

    output_bank_scheduler #(
        .WIDTH(WIDTH), .NREQ(NREQ), .HOLD_W(HOLD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_pattern(req_pattern),
        .req_hold(req_hold),
`ifdef OUTPUT_BANK_ABORT_EN
        .abort(abort),
`endif
        .gnt(gnt),
        .done(done),
        .out_bus(out_bus),
        .busy(busy),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] hold;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic [39:0] out;
        logic        busy;
        logic [2:0]  owner;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] rq,
                                input logic [31:0] h, input logic [3:0] g,
                                input logic [3:0] d, input logic [39:0] o,
                                input logic b, input logic [2:0] ow);
        vec_t v;
        v.rst = r; v.req = rq; v.hold = h; v.gnt = g;
        v.done = d; v.out = o; v.busy = b; v.owner = ow;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gnt and done must never coincide for one requester
    always @(negedge clk) begin
        if (!rst) chk("gnt_done_overlap", 64'(gnt & done), 64'd0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst         = 1'b1;
        req         = '0;
        req_hold    = 32'h01010101;
        req_pattern = {P3, P2, P1, P0};
`ifdef OUTPUT_BANK_ABORT_EN
        abort       = 1'b0;
`endif

        // reset held with all requests pending
        add(1, 4'hF, 32'h01010101, 0, 0, 0,  0, 0);
        add(1, 4'hF, 32'h01010101, 0, 0, 0,  0, 0);
        add(1, 4'hF, 32'h01010101, 0, 0, 0,  0, 0);
        // round robin, hold=1
        add(0, 4'hF, 32'h01010101, 1, 0, P0, 1, 0);
        add(0, 4'hF, 32'h01010101, 0, 1, 0,  1, 0);
        add(0, 4'hF, 32'h01010101, 2, 0, P1, 1, 1);
        add(0, 4'hF, 32'h01010101, 0, 2, 0,  1, 1);
        add(0, 4'hF, 32'h01010101, 4, 0, P2, 1, 2);
        add(0, 4'hF, 32'h01010101, 0, 4, 0,  1, 2);
        add(0, 4'hF, 32'h01010101, 8, 0, P3, 1, 3);
        add(0, 4'hF, 32'h01010101, 0, 8, 0,  1, 3);
        add(0, 4'hF, 32'h01010101, 1, 0, P0, 1, 0);
        add(0, 4'h0, 32'h01010101, 0, 1, 0,  1, 0);
        add(0, 4'h0, 32'h01010101, 0, 0, 0,  0, 0);
        // single requester 2, hold=3
        add(0, 4'h4, 32'h03030303, 4, 0, P2, 1, 2);
        add(0, 4'h0, 32'h03030303, 0, 0, P2, 1, 2);
        add(0, 4'h0, 32'h03030303, 0, 0, P2, 1, 2);
        add(0, 4'h0, 32'h03030303, 0, 4, 0,  1, 2);
        add(0, 4'h0, 32'h03030303, 0, 0, 0,  0, 2);
        // hold=0 behaves as 1
        add(0, 4'h2, 32'h00000000, 2, 0, P1, 1, 1);
        add(0, 4'h0, 32'h00000000, 0, 2, 0,  1, 1);
        add(0, 4'h0, 32'h00000000, 0, 0, 0,  0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            req      = vecs[i].req;
            req_hold = vecs[i].hold;
            step();
            chk($sformatf("v%0d gnt", i),   64'(gnt),     64'(vecs[i].gnt));
            chk($sformatf("v%0d done", i),  64'(done),    64'(vecs[i].done));
            chk($sformatf("v%0d out", i),   64'(out_bus), 64'(vecs[i].out));
            chk($sformatf("v%0d busy", i),  64'(busy),    64'(vecs[i].busy));
            chk($sformatf("v%0d owner", i), 64'(owner),   64'(vecs[i].owner));
        end

        // hold maximum: 255 DRIVE cycles
        req      = 4'h1;
        req_hold = 32'h000000FF;
        step();
        chk("max gnt", 64'(gnt), 64'h1);
        req = 4'h0;
        n = 0;
        for (int c = 0; c < 300; c++) begin
            if (out_bus != P0) break;
            n++;
            step();
        end
        chk("max drive cycles", 64'(n), 64'd255);
        chk("max done", 64'(done), 64'h1);
        chk("max guard out", 64'(out_bus), 64'd0);
        step();
        chk("max idle busy", 64'(busy), 64'd0);

        // reset during DRIVE cycle 4 of requester 3
        req      = 4'h8;
        req_hold = 32'h0A0A0A0A;
        step();
        chk("rstmid gnt", 64'(gnt), 64'h8);
        req = 4'h0;
        step();
        step();
        step();
        chk("rstmid cycle4 out", 64'(out_bus), 64'(P3));
        rst = 1'b1;
        step();
        chk("rstmid out", 64'(out_bus), 64'd0);
        chk("rstmid done", 64'(done), 64'd0);
        chk("rstmid busy", 64'(busy), 64'd0);
        rst      = 1'b0;
        req      = 4'hF;
        req_hold = 32'h01010101;
        step();
        chk("rstmid regrant", 64'(gnt), 64'h1);
        chk("rstmid regrant out", 64'(out_bus), 64'(P0));
        req = 4'h0;
        step();
        chk("rstmid guard done", 64'(done), 64'h1);
        step();
        chk("rstmid idle", 64'(busy), 64'd0);

`ifdef OUTPUT_BANK_ABORT_EN
        // abort at DRIVE cycle 5 with hold=20
        req      = 4'h1;
        req_hold = 32'h00000014;
        step();
        chk("abort gnt", 64'(gnt), 64'h1);
        req = 4'h0;
        n = 1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (out_bus == P0) n++;
        end
        chk("abort drive cycles", 64'(n), 64'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort out", 64'(out_bus), 64'd0);
        chk("abort done", 64'(done), 64'h1);
        chk("abort busy", 64'(busy), 64'd1);
        step();
        chk("abort idle", 64'(busy), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
